// File: rtl/scram_sched.sv
// ---------------------------------------------------------------------------
// scram_sched
//   Shares one N-bit scrambler among NREQ requesters and forwards each
//   scrambled byte to the UART transmitter. Requesters are served
//   round-robin. The winner's seed and plaintext are loaded into the
//   scrambler. The block then waits for the scrambler result, hands the
//   result to the UART and acknowledges the requester.
//
// Ports
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   req_valid      : per-requester request, held until its req_ack
//   req_data/seed  : packed plaintext/seed, requester i at [i*N +: N]
//   req_ack        : one-cycle completion pulse to the granted requester
//   req_err        : qualifies req_ack; 1 = scrambler timed out, nothing sent
//   busy           : high whenever an operation is in progress
//   scr_en         : one-cycle scrambler start pulse
//   scr_seed/data  : scrambler operands, held from grant until back in IDLE
//   scr_done       : scrambler completion pulse, scr_data_out valid with it
//   tx_busy        : UART transmitter busy
//   tx_start       : one-cycle UART start pulse
//   tx_data        : registered byte to transmit
//   tx_done        : UART end-of-frame pulse
// ---------------------------------------------------------------------------
module scram_sched #(
  parameter int N       = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ*N-1:0] req_seed,
  output logic [NREQ-1:0]   req_ack,
  output logic              req_err,
  output logic              busy,
  output logic              scr_en,
  output logic [N-1:0]      scr_seed,
  output logic [N-1:0]      scr_data,
  input  logic              scr_done,
  input  logic [N-1:0]      scr_data_out,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [N-1:0]      tx_data,
  input  logic              tx_done
);

  localparam int PW = $clog2(NREQ);
  localparam int SW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SCR,
    TX_START,
    WAIT_TX,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [7:0]    timer_q, timer_d;
  logic          err_q, err_d;
  logic [N-1:0]  scr_seed_q, scr_seed_d;
  logic [N-1:0]  scr_data_q, scr_data_d;
  logic [N-1:0]  tx_data_q, tx_data_d;

  logic          found;
  logic [SW-1:0] cand_sum;
  logic [PW-1:0] cand;

  logic [N-1:0]  data_arr [NREQ];
  logic [N-1:0]  seed_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*N +: N];
    assign seed_arr[gi] = req_seed[gi*N +: N];
  end

  // Next-state logic. In IDLE the candidates are scanned starting at
  // rr_ptr and wrapping. The first valid one wins, so the requester
  // served last is considered last next time.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    err_d      = err_q;
    scr_seed_d = scr_seed_q;
    scr_data_d = scr_data_q;
    tx_data_d  = tx_data_q;
    found      = 1'b0;
    cand_sum   = '0;
    cand       = '0;

    case (state_q)
      IDLE: begin
        for (int k = 0; k < NREQ; k++) begin
          cand_sum = SW'(rr_ptr_q) + SW'(k);
          if (cand_sum >= SW'(NREQ)) begin
            cand_sum = cand_sum - SW'(NREQ);
          end
          cand = cand_sum[PW-1:0];
          if (!found && req_valid[cand]) begin
            found      = 1'b1;
            grant_d    = cand;
            scr_data_d = data_arr[cand];
            scr_seed_d = seed_arr[cand];
          end
        end
        if (found) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        timer_d = '0;
        state_d = WAIT_SCR;
      end

      // scr_done is tested first so that it wins over a simultaneous timeout.
      WAIT_SCR: begin
        timer_d = timer_q + 8'd1;
        if (scr_done) begin
          tx_data_d = scr_data_out;
          state_d   = TX_START;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      TX_START: begin
        if (!tx_busy) begin
          state_d = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (tx_done) begin
          state_d = DONE;
        end
      end

      DONE: begin
        rr_ptr_d = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
        err_d    = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      scr_seed_q <= '0;
      scr_data_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      scr_seed_q <= scr_seed_d;
      scr_data_q <= scr_data_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Control outputs are decoded from the state register only. The one
  // exception is tx_start. It is gated by the live tx_busy so the pulse
  // lands in the first TX_START cycle where the UART is free. This keeps
  // the scr_en to tx_start latency at 10 cycles.
  assign busy     = (state_q != IDLE);
  assign scr_en   = (state_q == LOAD);
  assign tx_start = (state_q == TX_START) && !tx_busy;
  assign req_err  = (state_q == DONE) && err_q;
  assign scr_seed = scr_seed_q;
  assign scr_data = scr_data_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    req_ack = '0;
    if (state_q == DONE) begin
      req_ack[grant_q] = 1'b1;
    end
  end

endmodule

// File: doc/scram_sched.md
Name: scram_sched

Overview:
- Schedules the shared 8-bit scrambler among NREQ requesters, then forwards each scrambled byte to the UART transmitter.
- Arbitrates requests round-robin and loads the winner's seed and data into the scrambler.
- Waits for the scrambler's done pulse (its send_to_uart output), hands the result to the UART, and acknowledges the requester.
- Sits between the crypto front end (key/data sources) and the scrambler/UART pair.

Parameters:
- N, 8, data and seed width; must match the scrambler's N.
- NREQ, 2, number of requesters; legal range 2..4.
- TIMEOUT, 16, maximum cycles in WAIT_SCR before the operation aborts with an error; legal range 10..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held high until the matching req_ack.
- req_data  in  NREQ*N  plaintext bytes; requester i occupies bits [i*N +: N].
- req_seed  in  NREQ*N  seeds, same packing as req_data.
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- req_err  out  1  valid only while req_ack is high; 1 = scrambler timeout, byte not sent.
- busy  out  1  high whenever the state is not IDLE.
- scr_en  out  1  one-cycle start pulse to the scrambler.
- scr_seed  out  N  seed to the scrambler; held from grant until the return to IDLE.
- scr_data  out  N  plaintext to the scrambler; held from grant until the return to IDLE.
- scr_done  in  1  scrambler completion pulse.
- scr_data_out  in  N  scrambler result; valid in the cycle scr_done is high.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle UART start pulse.
- tx_data  out  N  byte to transmit; registered, held stable through WAIT_TX.
- tx_done  in  1  UART one-cycle end-of-frame pulse.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, grant=0, timer=0.
  - Outputs clear: req_ack=0, req_err=0, busy=0, scr_en=0, tx_start=0.
  - Data clears: scr_seed=0, scr_data=0, tx_data=0.
  - A reset mid-operation abandons the operation; no ack is issued for it.
- IDLE: if any req_valid is high, grant the first valid index at or after rr_ptr (wrapping modulo NREQ).
  - Register that requester's data into scr_data and its seed into scr_seed; go to LOAD.
  - No valid requests: stay in IDLE.
- LOAD: scr_en=1 for exactly this cycle; clear timer; go to WAIT_SCR.
- WAIT_SCR: timer increments every cycle.
  - scr_done=1: capture scr_data_out into tx_data; go to TX_START.
  - Otherwise, when timer reaches TIMEOUT-1: set err; go to DONE.
  - scr_done and timeout in the same cycle: scr_done wins.
  - The companion scrambler asserts scr_done 9 cycles after the scr_en cycle.
- TX_START: while tx_busy=1, wait.
  - When tx_busy=0: tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on tx_done=1, go to DONE. No timeout in this state.
- DONE: req_ack[grant]=1 for this cycle only; req_err = err.
  - rr_ptr = (grant+1) mod NREQ; clear err; go to IDLE.
- Fixed latency with tx_busy=0 and an immediate tx_done:
  - Grant edge to scr_en: 1 cycle.
  - scr_en to tx_start: 10 cycles.
- Request handling rules:
  - A req_valid that drops mid-operation is ignored; the operation completes and the ack is still pulsed.
  - New requests are not sampled outside IDLE.
  - A requester still valid after its ack is re-arbitrated; rr_ptr ensures the other requesters are served first.
- Spurious pulses: scr_done outside WAIT_SCR and tx_done outside WAIT_TX are ignored.
- At most one bit of req_ack is ever high. scr_en and tx_start are never high in the same cycle.

Test Plan:
1. Single request: req_valid=01, data=0xA5, seed=0x3C, tx_busy=0, tx_done returned 5 cycles after tx_start.
   - scr_en for 1 cycle; tx_data = A5 ^ model(seed 3C, 8 shifts); tx_start 10 cycles after scr_en.
   - req_ack=01 with req_err=0; busy drops the next cycle.
2. Fairness: req_valid=11 held continuously across 4 operations.
   - Grants alternate 0,1,0,1; req_ack sequence 01,10,01,10; no back-to-back grant to the same requester.
3. Timeout: scr_done tied low.
   - After exactly TIMEOUT cycles in WAIT_SCR: req_ack pulses with req_err=1; tx_start never asserts; next request proceeds normally.
4. UART backpressure: tx_busy=1 for 20 cycles when TX_START is entered.
   - tx_start is held off until the first cycle tx_busy=0; tx_data is unchanged throughout; the ack follows tx_done.
5. Reset mid-operation: assert rst during WAIT_SCR and again during WAIT_TX.
   - All outputs return to their reset values immediately; no req_ack; the next request is granted to index 0.
6. Spurious pulses and withdrawal: scr_done in IDLE, tx_done in WAIT_SCR, and req_valid dropped during WAIT_SCR.
   - No state change from the spurious pulses; the operation completes and acks the original grant.
